// File: rtl/dl_mul_pkg.sv
// dl_mul_pkg: shared types for the iterative RV32M multiplier.
// Provides the operation encoding (matches the 2-bit op port) and FSM states.
// Imported by dl_mul_step and dl_mul_iter.
package dl_mul_pkg;

  localparam int MUL_NUM_BITS_DFLT = 32;

  typedef enum logic [1:0] {
    MUL    = 2'd0,  // low half, sign-agnostic
    MULH   = 2'd1,  // signed x signed, high half
    MULHSU = 2'd2,  // signed x unsigned, high half
    MULHU  = 2'd3   // unsigned x unsigned, high half
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/dl_mul_step.sv
// dl_mul_step: one combinational radix-2 shift-and-add step.
// Ports: acc_i/mcand_i (2N bits), mplier_i (N bits) in; next acc/mcand/mplier out.
// Purely combinational, no latency, no flow control.
module dl_mul_step
  import dl_mul_pkg::*;
#(
  parameter int NUM_BITS = MUL_NUM_BITS_DFLT
) (
  input  logic [2*NUM_BITS-1:0] acc_i,
  input  logic [2*NUM_BITS-1:0] mcand_i,
  input  logic [NUM_BITS-1:0]   mplier_i,
  output logic [2*NUM_BITS-1:0] acc_o,
  output logic [2*NUM_BITS-1:0] mcand_o,
  output logic [NUM_BITS-1:0]   mplier_o
);

  // Add is modulo 2^(2N); magnitudes never exceed 2^N so nothing is lost.
  assign acc_o    = mplier_i[0] ? (acc_i + mcand_i) : acc_i;
  assign mcand_o  = mcand_i << 1;
  assign mplier_o = mplier_i >> 1;

endmodule

// File: rtl/dl_mul_iter.sv
// dl_mul_iter: iterative sign/magnitude shift-and-add multiplier (MUL/MULH/MULHSU/MULHU).
// Ports: clk, rst (sync, active-high); in_val/in_rdy/a/b/op operand side;
//        out_val/out_rdy/out result side. Fixed NUM_BITS-cycle latency, out held until taken.
module dl_mul_iter
  import dl_mul_pkg::*;
#(
  parameter int NUM_BITS = MUL_NUM_BITS_DFLT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_val,
  output logic                in_rdy,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic [1:0]          op,
  output logic                out_val,
  input  logic                out_rdy,
  output logic [NUM_BITS-1:0] out
);

  localparam int PW = 2 * NUM_BITS;
  localparam int CW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NUM_BITS - 1);

  mul_state_t          state_q;
  mul_op_t             op_q;
  logic                neg_q;
  logic [PW-1:0]       acc_q;
  logic [PW-1:0]       mcand_q;
  logic [NUM_BITS-1:0] mplier_q;
  logic [CW-1:0]       cnt_q;
  logic                out_val_q;
  logic [NUM_BITS-1:0] out_q;

  logic [PW-1:0]       acc_d;
  logic [PW-1:0]       mcand_d;
  logic [NUM_BITS-1:0] mplier_d;

  mul_op_t             op_in;
  logic                sign_a;
  logic                sign_b;
  logic [NUM_BITS-1:0] mag_a;
  logic [NUM_BITS-1:0] mag_b;
  logic [PW-1:0]       prod_fin;
  logic [NUM_BITS-1:0] out_sel;

  assign op_in = mul_op_t'(op);

  // Operands are treated as signed only where the op says so. Negating
  // the most negative value yields the same bit pattern, which read as an
  // unsigned N-bit magnitude is exactly right.
  always_comb begin
    sign_a = ((op_in == MULH) || (op_in == MULHSU)) && a[NUM_BITS-1];
    sign_b = (op_in == MULH) && b[NUM_BITS-1];
    mag_a  = sign_a ? (~a + NUM_BITS'(1)) : a;
    mag_b  = sign_b ? (~b + NUM_BITS'(1)) : b;
  end

  dl_mul_step #(
    .NUM_BITS (NUM_BITS)
  ) u_step (
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q),
    .acc_o    (acc_d),
    .mcand_o  (mcand_d),
    .mplier_o (mplier_d)
  );

  // Result of the final step, with the sign re-applied, then half-selected.
  always_comb begin
    prod_fin = neg_q ? (~acc_d + PW'(1)) : acc_d;
    out_sel  = (op_q == MUL) ? prod_fin[NUM_BITS-1:0] : prod_fin[PW-1:NUM_BITS];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= MUL;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      out_val_q <= 1'b0;
      out_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_val) begin
            op_q     <= op_in;
            neg_q    <= sign_a ^ sign_b;
            mcand_q  <= {{NUM_BITS{1'b0}}, mag_a};
            mplier_q <= mag_b;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            out_q     <= out_sel;
            out_val_q <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (out_rdy) begin
            out_val_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          out_val_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  // Only the registered state feeds in_rdy; rst masks it during reset.
  assign in_rdy  = (state_q == IDLE) && !rst;
  assign out_val = out_val_q;
  assign out     = out_q;

endmodule

// File: tb/tb_dl_mul_iter.sv
// tb_dl_mul_iter: randomized and directed bench for dl_mul_iter against a 64-bit arithmetic model.
// Ports: none; drives clk/rst and both handshakes, checks every result cycle.
// Result consumer stalls for a random or fixed number of cycles.
module tb_dl_mul_iter;

  logic        clk;
  logic        rst;
  logic        in_val;
  logic        in_rdy;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  op;
  logic        out_val;
  logic        out_rdy;
  logic [31:0] out;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] res;
    int          acc_cyc;
  } exp_t;

  exp_t expq[$];
  bit   prev_val = 1'b0;

  dl_mul_iter #(.NUM_BITS(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .a       (a),
    .b       (b),
    .op      (op),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out     (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: extend each operand per its signedness to 64 bits and multiply
  // modulo 2^64; the wanted half of that is the architectural result.
  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input logic [1:0] o);
    logic [63:0] ex, ey, p;
    ex = (o == 2'd1 || o == 2'd2) ? {{32{x[31]}}, x} : {32'h0, x};
    ey = (o == 2'd1) ? {{32{y[31]}}, y} : {32'h0, y};
    p  = ex * ey;
    return (o == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // Compare process: every cycle a result is presented it must match the
  // oldest outstanding expectation, and must first appear 32 cycles after accept.
  always @(negedge clk) begin
    if (rst) begin
      prev_val = 1'b0;
    end else begin
      if (out_val) begin
        if (expq.size() == 0) begin
          chk("spurious_out_val", 1, 0);
        end else begin
          chk("result", out, expq[0].res);
          if (!prev_val) chk("latency", cyc - expq[0].acc_cyc, 32);
          if (out_rdy) void'(expq.pop_front());
        end
      end
      prev_val = out_val;
    end
  end

  // One full operation. Called at posedge+#1. stall==0 keeps out_rdy high
  // from accept; otherwise out_rdy stays low for `stall` cycles of out_val.
  task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic [1:0] iop,
                       input int stall, input bit lit_en, input logic [31:0] lit,
                       input string nm);
    logic [31:0] got;
    int          t;
    bit          busy_bad;
    t = 0;
    while (!in_rdy && t < 50) begin
      @(posedge clk); #1; t++;
    end
    chk({nm, "_in_rdy_idle"}, in_rdy, 1);
    if (!in_rdy) finish_run();
    a = ia; b = ib; op = iop; in_val = 1'b1;
    out_rdy = (stall == 0);
    @(posedge clk); #1;
    expq.push_back('{res: ref_mul(ia, ib, iop), acc_cyc: cyc});
    in_val = 1'b0;
    t = 0;
    busy_bad = 1'b0;
    while (!out_val && t < 100) begin
      if (in_rdy) busy_bad = 1'b1;
      // Operand lines churn while busy; they must not be re-sampled.
      a = $urandom; b = $urandom; op = 2'($urandom); in_val = 1'($urandom);
      @(posedge clk); #1; t++;
    end
    if (!out_val) begin
      chk({nm, "_timeout"}, 1, 0);
      finish_run();
    end
    chk({nm, "_in_rdy_low_busy"}, busy_bad, 0);
    chk({nm, "_cycles"}, t, 32);
    got = out;
    for (int i = 0; i < stall; i++) begin
      chk({nm, "_hold_val"}, out_val, 1);
      chk({nm, "_hold_out"}, out, got);
      chk({nm, "_hold_in_rdy"}, in_rdy, 0);
      in_val = 1'b1; a = $urandom; b = $urandom;
      @(posedge clk); #1;
    end
    out_rdy = 1'b1;
    @(posedge clk); #1;
    in_val = 1'b0;
    out_rdy = 1'b0;
    chk({nm, "_out_val_after_hs"}, out_val, 0);
    chk({nm, "_in_rdy_after_hs"}, in_rdy, 1);
    if (lit_en) chk({nm, "_literal"}, got, lit);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    rst = 1'b1; in_val = 1'b0; a = '0; b = '0; op = '0; out_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_val", out_val, 0);
    chk("reset_out", out, 0);
    chk("reset_in_rdy", in_rdy, 0);
    rst = 1'b0;
    #1;
    chk("post_reset_in_rdy", in_rdy, 1);

    // Model pins.
    chk("model_mulh_min", ref_mul(32'h80000000, 32'h80000000, 2'd1), 32'h40000000);
    chk("model_mulhsu_m1", ref_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 2'd2), 32'hFFFFFFFF);

    do_op(32'd7, 32'd6, 2'd0, 0, 1'b1, 32'd42, "mul_7x6");
    do_op(32'h80000000, 32'h80000000, 2'd1, 0, 1'b1, 32'h40000000, "mulh_min");
    do_op(32'h80000000, 32'h80000000, 2'd0, 0, 1'b1, 32'h00000000, "mul_min");
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 2'd3, 0, 1'b1, 32'hFFFFFFFE, "mulhu_m1");
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 2'd1, 0, 1'b1, 32'h00000000, "mulh_m1");
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 2'd2, 0, 1'b1, 32'hFFFFFFFF, "mulhsu_m1");
    do_op(32'd3, 32'd5, 2'd0, 5, 1'b1, 32'd15, "mul_bp");

    // Reset in the middle of a MULHU.
    a = 32'h12345678; b = 32'h9ABCDEF0; op = 2'd3; in_val = 1'b1;
    @(posedge clk); #1;
    in_val = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_val", out_val, 0);
    chk("midrst_out", out, 0);
    chk("midrst_in_rdy", in_rdy, 0);
    rst = 1'b0;
    #1;
    chk("midrst_in_rdy_after", in_rdy, 1);
    do_op(32'd2, 32'hFFFFFFFD, 2'd0, 0, 1'b1, 32'hFFFFFFFA, "mul_2xm3");

    for (int n = 0; n < 1000; n++) begin
      ra = $urandom; rb = $urandom; rop = 2'($urandom);
      case ($urandom_range(0, 7))
        0: ra = 32'h80000000;
        1: rb = 32'hFFFFFFFF;
        2: ra = 32'h0;
        default: ;
      endcase
      do_op(ra, rb, rop, $urandom_range(0, 3), 1'b0, 32'h0, "rand");
    end

    repeat (2) @(posedge clk);
    chk("queue_drained", expq.size(), 0);
    finish_run();
  end

endmodule
